decode_stage_p: RTL and testbench

- Parametrised successor to the 16-bit decode stage.
- Contains the IF/ID pipeline register with valid, stall and flush, and a register file with R0 hardwired to zero and write-through bypass.
- Resolves branches in ID using N forwarding channels, and detects load-use and branch-operand hazards, using a stall counter for multi-cycle stalls.
- Sits between fetch and execute. The existing Control unit consumes id_ir.

---
 rtl/decode_pkg.sv | 22 ++
 rtl/regfile_p.sv | 55 +++++
 rtl/decode_stage_p.sv | 149 ++++++++++++++
 tb/tb_decode_stage_p.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Package  : decode_pkg
// Purpose  : Opcode / compare-code constants and width helper for decode_stage_p.
// Revision : 1.0
// ============================================================================
package decode_pkg;

  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_JR     = 3'b110;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_NE = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;
  localparam logic [1:0] CMP_GE = 2'b11;

  function automatic int calc_ra_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_p.sv
`default_nettype none
// ============================================================================
// Module   : regfile_p
// Purpose  : NUM_REGS x DATA_W register file, 3 read / 1 write, R0 = 0,
//            same-cycle write-through to the read ports.
// Revision : 1.0
// ============================================================================
module regfile_p
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int RA_W     = calc_ra_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  input  logic [RA_W-1:0]   raddr2,
  input  logic [RA_W-1:0]   raddr3,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [RA_W-1:0]   w_raddr [3];
  logic [DATA_W-1:0] w_rdata [3];

  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;
  assign w_raddr[2] = raddr3;
  assign rdata1     = w_rdata[0];
  assign rdata2     = w_rdata[1];
  assign rdata3     = w_rdata[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      r_mem[waddr] <= wdata;
    end
  end

  genvar g;
  for (g = 0; g < 3; g++) begin : g_rd
    assign w_rdata[g] = (w_raddr[g] == '0)                ? '0    :
                        (we && (w_raddr[g] == waddr))     ? wdata :
                                                            r_mem[w_raddr[g]];
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_p
// Purpose  : IF/ID register, register file, branch/JR resolution in ID with
//            NUM_FWD forwarding channels, load-use and operand hazard stalls.
// Revision : 1.0
// ============================================================================
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_FWD  = 2,
  parameter int RA_W     = calc_ra_w(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid,
  input  logic [DATA_W-1:0]         if_pc,
  input  logic [15:0]               if_ir,
  input  logic                      wb_we,
  input  logic [RA_W-1:0]           wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [RA_W-1:0]           ex_rd,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*RA_W-1:0]   fwd_rd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic                      id_valid,
  output logic [DATA_W-1:0]         id_pc,
  output logic [15:0]               id_ir,
  output logic [RA_W-1:0]           rs1,
  output logic [RA_W-1:0]           rs2,
  output logic [RA_W-1:0]           rd,
  output logic [DATA_W-1:0]         rs1_data,
  output logic [DATA_W-1:0]         rs2_data,
  output logic [DATA_W-1:0]         rs3_data,
  output logic [DATA_W-1:0]         imm,
  output logic                      stall,
  output logic                      redirect,
  output logic [DATA_W-1:0]         redirect_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [1:0]        r_stall_cnt;

  logic [DATA_W-1:0] w_op1, w_op2, w_op3;
  logic [5:0]        w_imm_raw;
  logic              w_is_br, w_is_jr, w_cond;
  logic              w_hit1, w_hit2, w_hit3;
  logic              w_load_use, w_br_hazard;

  assign id_pc     = r_pc;
  assign id_ir     = r_ir;
  assign rs1       = r_ir[6 +: RA_W];
  assign rs2       = r_ir[9 +: RA_W];
  assign rd        = r_ir[3 +: RA_W];
  assign w_imm_raw = {r_ir[15:14], r_ir[5:3], 1'b0};
  assign imm       = {{(DATA_W-6){w_imm_raw[5]}}, w_imm_raw};

  regfile_p #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RA_W     (RA_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .raddr3 (rd),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .rdata3 (rs3_data)
  );

  // Descending scan so the lowest-index (youngest) matching channel wins.
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [RA_W-1:0]           src,
    input logic [DATA_W-1:0]         rf_val,
    input logic [NUM_FWD-1:0]        f_valid,
    input logic [NUM_FWD*RA_W-1:0]   f_rd,
    input logic [NUM_FWD*DATA_W-1:0] f_data
  );
    logic [DATA_W-1:0] res;
    res = rf_val;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (f_valid[i] && (f_rd[i*RA_W +: RA_W] == src)) res = f_data[i*DATA_W +: DATA_W];
    end
    if (src == '0) res = '0;
    return res;
  endfunction

  assign w_op1 = fwd_pick(rs1, rs1_data, fwd_valid, fwd_rd, fwd_data);
  assign w_op2 = fwd_pick(rs2, rs2_data, fwd_valid, fwd_rd, fwd_data);
  assign w_op3 = fwd_pick(rd,  rs3_data, fwd_valid, fwd_rd, fwd_data);

  assign w_is_br = (r_ir[2:0] == OP_BRANCH);
  assign w_is_jr = (r_ir[2:0] == OP_JR);

  always_comb begin
    w_cond = 1'b0;
    case (r_ir[13:12])
      CMP_EQ:  w_cond = (w_op1 == w_op2);
      CMP_NE:  w_cond = (w_op1 != w_op2);
      CMP_LT:  w_cond = ($signed(w_op1) <  $signed(w_op2));
      CMP_GE:  w_cond = ($signed(w_op1) >= $signed(w_op2));
      default: w_cond = 1'b0;
    endcase
  end

  assign w_hit1      = (rs1 != '0) && (ex_rd == rs1);
  assign w_hit2      = (rs2 != '0) && (ex_rd == rs2);
  assign w_hit3      = (rd  != '0) && (ex_rd == rd);
  assign w_load_use  = r_valid && ex_mem_read && (w_hit1 || w_hit2);
  assign w_br_hazard = r_valid && ex_reg_write &&
                       ((w_is_br && (w_hit1 || w_hit2)) || (w_is_jr && w_hit3));

  assign stall       = w_load_use || w_br_hazard || (r_stall_cnt != 2'd0);
  assign id_valid    = r_valid && !stall;
  assign redirect    = id_valid && ((w_is_br && w_cond) || w_is_jr);
  assign redirect_pc = w_is_jr ? w_op3 : (r_pc + imm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_ir        <= '0;
      r_stall_cnt <= 2'd0;
    end else begin
      // A branch whose operand is still being loaded needs a second stall cycle.
      if (r_stall_cnt != 2'd0)             r_stall_cnt <= r_stall_cnt - 2'd1;
      else if (w_br_hazard && ex_mem_read) r_stall_cnt <= 2'd1;

      if (!stall) begin
        r_valid <= if_valid && !redirect;
        r_pc    <= if_pc;
        r_ir    <= if_ir;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_p
// Purpose  : Directed and randomised checks of decode_stage_p against a
//            cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_decode_stage_p;
  import decode_pkg::*;

  localparam int DATA_W = 16;
  localparam int NUM_REGS = 8;
  localparam int NUM_FWD = 2;
  localparam int RA_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid, wb_we, ex_reg_write, ex_mem_read;
  logic [15:0] if_pc, if_ir, wb_data;
  logic [2:0]  wb_addr, ex_rd;
  logic [1:0]  fwd_valid;
  logic [5:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        id_valid, stall, redirect;
  logic [15:0] id_pc, id_ir, rs1_data, rs2_data, rs3_data, imm, redirect_pc;
  logic [2:0]  rs1, rs2, rd;

  int vectors = 0;
  int errors = 0;

  // behavioural model state
  logic [15:0] m_regs [NUM_REGS];
  logic        m_valid;
  logic [15:0] m_pc, m_ir;
  int          m_extra;
  logic        e_valid, e_stall, e_redirect, e_bh;
  logic [15:0] e_rpc, e_rs1d, e_rs2d, e_rs3d, e_imm;

  decode_stage_p #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data), .imm(imm),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [1:0] cmp, input logic [1:0] ih);
    return {ih, cmp, s2, s1, d, op};
  endfunction

  function automatic logic [15:0] m_read(input int a);
    if (a == 0) return 16'h0;
    if (wb_we && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [15:0] m_operand(input int a);
    if (a == 0) return 16'h0;
    for (int i = 0; i < NUM_FWD; i++)
      if (fwd_valid[i] && int'(fwd_rd[i*3 +: 3]) == a) return fwd_data[i*16 +: 16];
    return m_read(a);
  endfunction

  function automatic void model_eval();
    int s1, s2, s3;
    logic [15:0] a, b;
    logic cond, br, jr, h1, h2, h3, lu;
    s1 = int'(m_ir[8:6]); s2 = int'(m_ir[11:9]); s3 = int'(m_ir[5:3]);
    e_rs1d = m_read(s1); e_rs2d = m_read(s2); e_rs3d = m_read(s3);
    e_imm = {{10{m_ir[15]}}, m_ir[15:14], m_ir[5:3], 1'b0};
    a = m_operand(s1); b = m_operand(s2);
    br = (m_ir[2:0] == 3'b011); jr = (m_ir[2:0] == 3'b110);
    case (m_ir[13:12])
      2'd0:    cond = (a == b);
      2'd1:    cond = (a != b);
      2'd2:    cond = ($signed(a) < $signed(b));
      default: cond = ($signed(a) >= $signed(b));
    endcase
    h1 = (s1 != 0) && (int'(ex_rd) == s1);
    h2 = (s2 != 0) && (int'(ex_rd) == s2);
    h3 = (s3 != 0) && (int'(ex_rd) == s3);
    lu = m_valid && ex_mem_read && (h1 || h2);
    e_bh = m_valid && ex_reg_write && ((br && (h1 || h2)) || (jr && h3));
    e_stall = lu || e_bh || (m_extra > 0);
    e_valid = m_valid && !e_stall;
    e_redirect = e_valid && ((br && cond) || jr);
    e_rpc = jr ? m_operand(s3) : m_pc + e_imm;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0;
    m_valid = 1'b0; m_pc = 16'h0; m_ir = 16'h0; m_extra = 0;
  endtask

  // Commit the model for the coming rising edge, then move to the next falling edge.
  task automatic advance();
    model_eval();
    if (m_extra > 0) m_extra--;
    else if (e_bh && ex_mem_read) m_extra = 1;
    if (wb_we && wb_addr != 3'd0) m_regs[wb_addr] = wb_data;
    if (!e_stall) begin
      m_valid = if_valid && !e_redirect; m_pc = if_pc; m_ir = if_ir;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid = 0; if_pc = 0; if_ir = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0; fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    idle(); wb_we = 1; wb_addr = a; wb_data = d; advance(); idle();
  endtask

  task automatic load_id(input logic [15:0] pc, input logic [15:0] ir);
    idle(); if_valid = 1; if_pc = pc; if_ir = ir; advance(); idle();
  endtask

  task automatic test_reset();
    idle(); model_reset();
    @(negedge clk); #1;
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    vectors++; if (redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect: got %b want 0", redirect); end
    vectors++; if (id_pc !== 16'h0 || id_ir !== 16'h0) begin errors++; $display("FAIL rst_pc_ir: got %h/%h want 0/0", id_pc, id_ir); end
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_writethrough();
    load_id(16'h0010, mk(3'd0, 3'd0, 3'd3, 3'd0, 2'd0, 2'd0));
    wb_we = 1; wb_addr = 3'd3; wb_data = 16'h1234; #1;
    vectors++; if (rs1_data !== 16'h1234) begin errors++; $display("FAIL wt_bypass: got %h want 1234", rs1_data); end
    advance();
    load_id(16'h0012, mk(3'd0, 3'd0, 3'd3, 3'd0, 2'd0, 2'd0));
    wb_we = 1; wb_addr = 3'd0; wb_data = 16'hFFFF; #1;
    vectors++; if (rs1_data !== 16'h1234) begin errors++; $display("FAIL wt_stored: got %h want 1234", rs1_data); end
    advance();
    load_id(16'h0014, mk(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0));
    wb_we = 1; wb_addr = 3'd0; wb_data = 16'hBEEF; #1;
    vectors++; if (rs1_data !== 16'h0) begin errors++; $display("FAIL r0_bypass: got %h want 0", rs1_data); end
    idle(); #1;
    vectors++; if (rs2_data !== 16'h0) begin errors++; $display("FAIL r0_read: got %h want 0", rs2_data); end
    advance();
  endtask

  task automatic test_beq_fwd();
    wb_write(3'd1, 16'd5);
    load_id(16'h0040, mk(OP_BRANCH, 3'b010, 3'd1, 3'd2, CMP_EQ, 2'b11));
    if_valid = 1; if_pc = 16'h0042; if_ir = mk(3'd0, 3'd1, 3'd1, 3'd1, 2'd0, 2'd0); #1;
    vectors++; if (redirect !== 1'b0) begin errors++; $display("FAIL beq_nofwd: got %b want 0", redirect); end
    fwd_valid = 2'b10; fwd_rd = {3'd2, 3'd0}; fwd_data = {16'd5, 16'd0}; #1;
    vectors++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", redirect); end
    vectors++; if (redirect_pc !== 16'h0034) begin errors++; $display("FAIL beq_target: got %h want 0034", redirect_pc); end
    advance(); idle(); #1;
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL beq_squash: got %b want 0", id_valid); end
    advance();
  endtask

  task automatic test_fwd_priority();
    wb_write(3'd2, 16'd8);
    load_id(16'h0100, mk(OP_BRANCH, 3'b001, 3'd5, 3'd2, CMP_LT, 2'b00));
    fwd_valid = 2'b11; fwd_rd = {3'd5, 3'd5}; fwd_data = {16'd9, 16'd7}; #1;
    vectors++; if (redirect !== 1'b1) begin errors++; $display("FAIL prio_ch0: got %b want 1", redirect); end
    vectors++; if (redirect_pc !== 16'h0102) begin errors++; $display("FAIL prio_target: got %h want 0102", redirect_pc); end
    fwd_valid = 2'b10; #1;
    vectors++; if (redirect !== 1'b0) begin errors++; $display("FAIL prio_ch1: got %b want 0", redirect); end
    advance(); idle();
  endtask

  task automatic test_load_use();
    logic [15:0] add_ir, nxt_ir;
    add_ir = mk(3'd0, 3'd1, 3'd4, 3'd0, 2'd0, 2'd0);
    nxt_ir = mk(3'd0, 3'd2, 3'd1, 3'd1, 2'd0, 2'd0);
    load_id(16'h0200, add_ir);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3'd4;
    if_valid = 1; if_pc = 16'h0202; if_ir = nxt_ir; #1;
    vectors++; if (stall !== 1'b1 || id_valid !== 1'b0) begin errors++; $display("FAIL lu_stall: got stall=%b valid=%b want 1/0", stall, id_valid); end
    advance();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; #1;
    vectors++; if (stall !== 1'b0 || id_valid !== 1'b1) begin errors++; $display("FAIL lu_release: got stall=%b valid=%b want 0/1", stall, id_valid); end
    vectors++; if (id_ir !== add_ir) begin errors++; $display("FAIL lu_issue: got %h want %h", id_ir, add_ir); end
    advance(); if_valid = 0; #1;
    vectors++; if (id_ir !== nxt_ir || id_valid !== 1'b1) begin errors++; $display("FAIL lu_next: got %h/%b want %h/1", id_ir, id_valid, nxt_ir); end
    advance(); idle();
  endtask

  task automatic test_branch_load();
    load_id(16'h0300, mk(OP_BRANCH, 3'd0, 3'd4, 3'd0, CMP_NE, 2'd0));
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3'd4; if_valid = 1; if_pc = 16'h0302; #1;
    vectors++; if (stall !== 1'b1 || redirect !== 1'b0) begin errors++; $display("FAIL bl_cyc1: got stall=%b redir=%b want 1/0", stall, redirect); end
    advance();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; #1;
    vectors++; if (stall !== 1'b1 || redirect !== 1'b0) begin errors++; $display("FAIL bl_cyc2: got stall=%b redir=%b want 1/0", stall, redirect); end
    advance();
    fwd_valid = 2'b01; fwd_rd = {3'd0, 3'd4}; fwd_data = {16'd0, 16'd5}; #1;
    vectors++; if (stall !== 1'b0 || redirect !== 1'b1) begin errors++; $display("FAIL bl_cyc3: got stall=%b redir=%b want 0/1", stall, redirect); end
    vectors++; if (redirect_pc !== 16'h0300) begin errors++; $display("FAIL bl_target: got %h want 0300", redirect_pc); end
    advance(); idle();
    // same hazard, reset arrives during the second stall cycle
    load_id(16'h0300, mk(OP_BRANCH, 3'd0, 3'd4, 3'd0, CMP_NE, 2'd0));
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3'd4; advance();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL blr_pre: got %b want 1", stall); end
    rst_n = 1'b0; #1;
    vectors++; if (stall !== 1'b0 || id_valid !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL blr_reset: got stall=%b valid=%b redir=%b want 0/0/0", stall, id_valid, redirect); end
    model_reset(); rst_n = 1'b1; advance(); #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL blr_after: got %b want 0", stall); end
    advance();
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int n = 0; n < 400; n++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r[2:0] = 3'b011;
        1: r[2:0] = 3'b110;
        default: ;
      endcase
      if_valid = ($urandom_range(0, 3) != 0); if_pc = 16'($urandom); if_ir = r;
      wb_we = $urandom_range(0, 1) == 1; wb_addr = 3'($urandom); wb_data = 16'($urandom);
      ex_mem_read = ($urandom_range(0, 3) == 0); ex_reg_write = ex_mem_read || ($urandom_range(0, 1) == 1);
      ex_rd = 3'($urandom); fwd_valid = 2'($urandom); fwd_rd = 6'($urandom); fwd_data = $urandom;
      #1; model_eval();
      vectors++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, e_stall); end
      vectors++; if (id_valid !== e_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, id_valid, e_valid); end
      vectors++; if (redirect !== e_redirect) begin errors++; $display("FAIL rnd_redirect[%0d]: got %b want %b", n, redirect, e_redirect); end
      vectors++; if ({rs1_data, rs2_data, rs3_data} !== {e_rs1d, e_rs2d, e_rs3d}) begin errors++; $display("FAIL rnd_reads[%0d]: got %h %h %h want %h %h %h", n, rs1_data, rs2_data, rs3_data, e_rs1d, e_rs2d, e_rs3d); end
      vectors++; if (imm !== e_imm) begin errors++; $display("FAIL rnd_imm[%0d]: got %h want %h", n, imm, e_imm); end
      if (e_redirect) begin
        vectors++; if (redirect_pc !== e_rpc) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", n, redirect_pc, e_rpc); end
      end
      if (e_valid) begin
        vectors++; if (id_pc !== m_pc || id_ir !== m_ir) begin errors++; $display("FAIL rnd_pcir[%0d]: got %h/%h want %h/%h", n, id_pc, id_ir, m_pc, m_ir); end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_reset_activity();
    for (int k = 1; k < 8; k++) begin
      idle(); wb_we = 1; wb_addr = 3'(k); wb_data = 16'(k * 16'h0111);
      if_valid = 1; if_pc = 16'(k); if_ir = mk(3'd0, 3'(k), 3'(k), 3'(k), 2'd0, 2'd0);
      advance();
    end
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3'd7; #1;
    rst_n = 1'b0; #1;
    vectors++; if (id_valid !== 1'b0 || stall !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL ra_reset: got valid=%b stall=%b redir=%b want 0/0/0", id_valid, stall, redirect); end
    model_reset(); idle(); rst_n = 1'b1; advance();
    for (int k = 1; k <= 8; k++) begin
      idle();
      if (k < 8) begin if_valid = 1; if_pc = 16'(k); if_ir = mk(3'd0, 3'(k), 3'(k), 3'(k), 2'd0, 2'd0); end
      #1;
      if (k > 1) begin
        vectors++; if ({rs1_data, rs2_data, rs3_data} !== 48'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL ra_reads[%0d]: got %h %h %h valid=%b want 0 0 0 1", k - 1, rs1_data, rs2_data, rs3_data, id_valid); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_writethrough();
    test_beq_fwd();
    test_fwd_priority();
    test_load_use();
    test_branch_load();
    test_random();
    test_reset_activity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
